scemi_in_pipe_put_packer: RTL and testbench

//  Upstream feeder for the SCE-MI input-pipe put proxy. Accepts narrow beats on a valid/ready stream
//  and packs BEATS beats into one WIDTH-bit pipe element. Buffers completed elements in a small FIFO.

---
 rtl/scemi_in_pipe_put_packer_pkg.sv | 15 +
 rtl/scemi_in_pipe_put_packer_if.sv | 30 +++
 rtl/scemi_elem_fifo.sv | 69 ++++++
 rtl/scemi_in_pipe_put_packer.sv | 97 +++++++++
 tb/tb_scemi_in_pipe_put_packer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/scemi_in_pipe_put_packer_pkg.sv
// Shared parameters and helpers for the SCE-MI input-pipe put packer.
// Defaults describe the standard 8-bit x 4-beat build.
package scemi_in_pipe_put_packer_pkg;

    localparam int unsigned IN_WIDTH_DEF = 8;
    localparam int unsigned BEATS_DEF    = 4;
    localparam int unsigned DEPTH_DEF    = 2;
    localparam int unsigned CNT_W        = 32;

    // Index width that stays at least 1 bit for single-entry structures.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scemi_in_pipe_put_packer_if.sv
// Beat stream in, pipe-element put out, plus the delivered-element counter.
// The slave modport is the packer's view; master is the environment's view.
interface scemi_in_pipe_put_packer_if
    import scemi_in_pipe_put_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH = IN_WIDTH_DEF,
    parameter int unsigned BEATS    = BEATS_DEF
);
    localparam int unsigned WIDTH = IN_WIDTH * BEATS;

    logic [IN_WIDTH-1:0] in_dat;
    logic                in_vld;
    logic                in_last;
    logic                in_rdy;
    logic [WIDTH-1:0]    data;
    logic                data_en;
    logic                data_rdy;
    logic [CNT_W-1:0]    elem_count;

    modport master (
        output in_dat, in_vld, in_last, data_rdy,
        input  in_rdy, data, data_en, elem_count
    );

    modport slave (
        input  in_dat, in_vld, in_last, data_rdy,
        output in_rdy, data, data_en, elem_count
    );

endinterface

// File: rtl/scemi_elem_fifo.sv
// Completed-element FIFO: register array, mod-DEPTH pointers, occupancy counter.
// Head is visible combinationally; push is dropped when full, pop ignored when empty.
module scemi_elem_fifo
    import scemi_in_pipe_put_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PW = idx_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is cleared too so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/scemi_in_pipe_put_packer.sv
// Packs BEATS narrow beats (or fewer, closed by in_last) into one pipe element for the put proxy.
// One-cycle latency from completing beat to put; beats stall only on a full element FIFO.
module scemi_in_pipe_put_packer
    import scemi_in_pipe_put_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH = IN_WIDTH_DEF,
    parameter int unsigned BEATS    = BEATS_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cnt_ld_i,
    input  logic [CNT_W-1:0]       cnt_ld_val_i,
    scemi_in_pipe_put_packer_if.slave pif
);
    localparam int unsigned WIDTH = IN_WIDTH * BEATS;
    localparam int unsigned LW    = idx_w(BEATS);

    logic                rst_an;
    logic [LW-1:0]       lane_q, lane_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic                ready_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    beat_word;
    logic [WIDTH-1:0]    elem_dat;
    logic                beat_acc, completing;
    logic                fifo_full, fifo_empty;

    // Builds using the shared positive-reset polarity get the input inverted here.
`ifdef SCEMI_POSITIVE_RESET
    assign rst_an = ~rst_n;
`else
    assign rst_an = rst_n;
`endif

    assign pif.in_rdy  = ready_q && !fifo_full;
    assign pif.data_en = !fifo_empty && pif.data_rdy;
    assign pif.elem_count = cnt_q;

    assign beat_acc   = pif.in_vld && pif.in_rdy;
    assign completing = beat_acc && (pif.in_last || (lane_q == LW'(BEATS - 1)));
    assign elem_dat   = acc_q | beat_word;

    always_comb begin
        beat_word = '0;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (lane_q == LW'(i)) beat_word[i*IN_WIDTH +: IN_WIDTH] = pif.in_dat;
        end
    end

    always_comb begin
        lane_d = lane_q;
        acc_d  = acc_q;
        if (completing) begin
            lane_d = '0;
            acc_d  = '0;
        end else if (beat_acc) begin
            lane_d = lane_q + LW'(1);
            acc_d  = elem_dat;
        end
    end

    // Debug preload wins over the delivery increment.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(pif.data_en);
        if (cnt_ld_i) cnt_d = cnt_ld_val_i;
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            lane_q  <= '0;
            acc_q   <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            ready_q <= 1'b1;
            cnt_q   <= cnt_d;
        end
    end

    scemi_elem_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_an),
        .push_i     (completing),
        .push_dat_i (elem_dat),
        .pop_i      (pif.data_en),
        .head_dat_o (pif.data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_scemi_in_pipe_put_packer.sv
// Directed bench for the put packer: 8-bit beats, 4 beats per element, 2-entry FIFO.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_scemi_in_pipe_put_packer;
    import scemi_in_pipe_put_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_ld = 1'b0;
    logic [31:0] cnt_ld_val = '0;

    int total  = 0;
    int bad    = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    scemi_in_pipe_put_packer_if #(.IN_WIDTH(8), .BEATS(4)) pif ();

    scemi_in_pipe_put_packer #(
        .IN_WIDTH (8),
        .BEATS    (4),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt_ld_i     (cnt_ld),
        .cnt_ld_val_i (cnt_ld_val),
        .pif          (pif)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_beat(input logic [7:0] d, input logic last);
        int w;
        pif.in_dat  = d;
        pif.in_last = last;
        pif.in_vld  = 1'b1;
        w = 0;
        #0;
        while (!pif.in_rdy && w < 50) begin
            stalls++;
            step();
            w++;
        end
        if (!pif.in_rdy) begin
            chk("beat_timeout", 64'(pif.in_rdy), 64'd1);
        end else begin
            step();
        end
        pif.in_vld  = 1'b0;
        pif.in_last = 1'b0;
    endtask

    task automatic put_elem(input logic [31:0] w);
        for (int i = 0; i < 4; i++) put_beat(w[i*8 +: 8], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pif.in_dat   = '0;
        pif.in_vld   = 1'b0;
        pif.in_last  = 1'b0;
        pif.data_rdy = 1'b1;

        // Reset state
        step(2);
        chk("rst_in_rdy", 64'(pif.in_rdy), 64'd0);
        chk("rst_data_en", 64'(pif.data_en), 64'd0);
        chk("rst_data", 64'(pif.data), 64'd0);
        chk("rst_count", 64'(pif.elem_count), 64'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 64'(pif.in_rdy), 64'd1);

        // 1: full element, put one cycle after the closing beat
        put_elem(32'h44332211);
        chk("t1_data_en", 64'(pif.data_en), 64'd1);
        chk("t1_data", 64'(pif.data), 64'h44332211);
        step();
        chk("t1_count", 64'(pif.elem_count), 64'd1);
        chk("t1_data_en_off", 64'(pif.data_en), 64'd0);

        // 2: early close, then a clean full element
        put_beat(8'hAA, 1'b0);
        put_beat(8'hBB, 1'b1);
        chk("t2_short_data", 64'(pif.data), 64'h0000BBAA);
        chk("t2_short_en", 64'(pif.data_en), 64'd1);
        step();
        put_elem(32'h04030201);
        chk("t2_full_data", 64'(pif.data), 64'h04030201);
        step();
        chk("t2_count", 64'(pif.elem_count), 64'd3);

        // 3: backpressure fills the FIFO, refused in_last beats are ignored
        pif.data_rdy = 1'b0;
        for (int i = 0; i < 8; i++) put_beat(8'(8'h10 + i), 1'b0);
        chk("t3_full_in_rdy", 64'(pif.in_rdy), 64'd0);
        chk("t3_full_data_en", 64'(pif.data_en), 64'd0);
        chk("t3_head", 64'(pif.data), 64'h13121110);
        pif.in_dat  = 8'hEE;
        pif.in_last = 1'b1;
        pif.in_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_in_rdy", 64'(pif.in_rdy), 64'd0);
            chk("t3_hold_head", 64'(pif.data), 64'h13121110);
        end
        pif.in_vld  = 1'b0;
        pif.in_last = 1'b0;
        chk("t3_count_held", 64'(pif.elem_count), 64'd3);
        pif.data_rdy = 1'b1;
        #1;
        chk("t3_drain_en", 64'(pif.data_en), 64'd1);
        chk("t3_drain_a", 64'(pif.data), 64'h13121110);
        step();
        chk("t3_count_a", 64'(pif.elem_count), 64'd4);
        chk("t3_drain_b", 64'(pif.data), 64'h17161514);
        chk("t3_in_rdy_back", 64'(pif.in_rdy), 64'd1);
        step();
        chk("t3_count_b", 64'(pif.elem_count), 64'd5);
        chk("t3_empty_en", 64'(pif.data_en), 64'd0);
        for (int i = 8; i < 12; i++) put_beat(8'(8'h10 + i), 1'b0);
        chk("t3_third", 64'(pif.data), 64'h1B1A1918);
        step();
        chk("t3_count_c", 64'(pif.elem_count), 64'd6);

        // 4: continuous stream never stalls
        stalls = 0;
        for (int i = 0; i < 20; i++) put_beat(8'(8'h20 + i), 1'b0);
        chk("t4_stalls", 64'(stalls), 64'd0);
        chk("t4_last_data", 64'(pif.data), 64'h33323130);
        step();
        chk("t4_count", 64'(pif.elem_count), 64'd11);

        // 5: reset mid-operation discards buffered and partial elements
        pif.data_rdy = 1'b0;
        put_elem(32'h43424140);
        put_beat(8'h50, 1'b0);
        put_beat(8'h51, 1'b0);
        rst_n = 1'b0;
        pif.data_rdy = 1'b1;
        #1;
        chk("t5_rst_data_en", 64'(pif.data_en), 64'd0);
        chk("t5_rst_in_rdy", 64'(pif.in_rdy), 64'd0);
        chk("t5_rst_count", 64'(pif.elem_count), 64'd0);
        chk("t5_rst_data", 64'(pif.data), 64'd0);
        step(2);
        rst_n = 1'b1;
        put_elem(32'h64636261);
        chk("t5_after_data", 64'(pif.data), 64'h64636261);
        chk("t5_after_en", 64'(pif.data_en), 64'd1);
        step();
        chk("t5_after_count", 64'(pif.elem_count), 64'd1);

        // 6: counter wrap
        cnt_ld     = 1'b1;
        cnt_ld_val = 32'hFFFF_FFFF;
        step();
        cnt_ld = 1'b0;
        chk("t6_preload", 64'(pif.elem_count), 64'hFFFF_FFFF);
        put_elem(32'h74737271);
        step();
        chk("t6_wrap0", 64'(pif.elem_count), 64'd0);
        put_elem(32'h84838281);
        chk("t6_data", 64'(pif.data), 64'h84838281);
        step();
        chk("t6_wrap1", 64'(pif.elem_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
